// File: rtl/face_det_pkg.sv
// Shared definitions for the face-detection merger: default field widths,
// detection-entry layout and merger state encoding.
package face_det_pkg;

    localparam int FD_COORD_WIDTH = 8;
    localparam int FD_HIT_WIDTH   = 4;

    // Entry layout, LSB first: x, y, scale, hits
    localparam int FD_FIELD_X = 0;
    localparam int FD_FIELD_Y = 1;
    localparam int FD_FIELD_S = 2;
    localparam int FD_FIELD_H = 3;

    function automatic int fd_lsb(input int field, input int cw);
        return field * cw;
    endfunction

    function automatic int fd_entry_w(input int cw, input int hw);
        return 3 * cw + hw;
    endfunction

    localparam logic [2:0] FD_S_IDLE    = 3'd0;
    localparam logic [2:0] FD_S_COLLECT = 3'd1;
    localparam logic [2:0] FD_S_SCAN    = 3'd2;
    localparam logic [2:0] FD_S_INSERT  = 3'd3;
    localparam logic [2:0] FD_S_READOUT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = FD_S_IDLE,
        ST_COLLECT = FD_S_COLLECT,
        ST_SCAN    = FD_S_SCAN,
        ST_INSERT  = FD_S_INSERT,
        ST_READOUT = FD_S_READOUT
    } fd_state_t;

endpackage

// File: rtl/det_match_cmp.sv
// Combinational proximity test of one stored entry against the latched detection.
module det_match_cmp #(
    parameter int COORD_WIDTH = 8,
    parameter int MERGE_DIST  = 4
) (
    input  logic [COORD_WIDTH-1:0] i_ent_x,
    input  logic [COORD_WIDTH-1:0] i_ent_y,
    input  logic [COORD_WIDTH-1:0] i_ent_s,
    input  logic [COORD_WIDTH-1:0] i_det_x,
    input  logic [COORD_WIDTH-1:0] i_det_y,
    input  logic [COORD_WIDTH-1:0] i_det_s,
    output logic                   o_match
);

    localparam logic [COORD_WIDTH:0] DIST  = (COORD_WIDTH+1)'(MERGE_DIST);
    localparam logic [COORD_WIDTH:0] S_TOL = (COORD_WIDTH+1)'(1);

    // One extra bit keeps the subtraction free of wrap-around
    function automatic logic [COORD_WIDTH:0] abs_diff(input logic [COORD_WIDTH-1:0] a,
                                                      input logic [COORD_WIDTH-1:0] b);
        logic [COORD_WIDTH:0] ea;
        logic [COORD_WIDTH:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    logic [COORD_WIDTH:0] w_dx;
    logic [COORD_WIDTH:0] w_dy;
    logic [COORD_WIDTH:0] w_ds;

    assign w_dx    = abs_diff(i_ent_x, i_det_x);
    assign w_dy    = abs_diff(i_ent_y, i_det_y);
    assign w_ds    = abs_diff(i_ent_s, i_det_s);
    assign o_match = (w_dx <= DIST) && (w_dy <= DIST) && (w_ds <= S_TOL);

endmodule

// File: rtl/face_detection_merger.sv
// Collects per-window face hits of a frame, merges near-duplicates into counted
// entries, and streams entries with enough hits out over valid/ready.
module face_detection_merger
    import face_det_pkg::*;
#(
    parameter int MAX_DET     = 16,
    parameter int COORD_WIDTH = FD_COORD_WIDTH,
    parameter int MERGE_DIST  = 4,
    parameter int MIN_HITS    = 2,
    parameter int HIT_WIDTH   = FD_HIT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   det_valid,
    output logic                   det_ready,
    input  logic [COORD_WIDTH-1:0] det_x,
    input  logic [COORD_WIDTH-1:0] det_y,
    input  logic [COORD_WIDTH-1:0] det_scale,
    input  logic                   frame_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_y,
    output logic [COORD_WIDTH-1:0] out_scale,
    output logic [HIT_WIDTH-1:0]   out_hits,
    output logic                   readout_done,
    output logic                   overflow,
    output logic                   busy
);

    localparam int CNT_W   = $clog2(MAX_DET + 1);
    localparam int IDX_W   = (MAX_DET > 1) ? $clog2(MAX_DET) : 1;
    localparam int ENTRY_W = fd_entry_w(COORD_WIDTH, HIT_WIDTH);
    localparam int X_LSB   = fd_lsb(FD_FIELD_X, COORD_WIDTH);
    localparam int Y_LSB   = fd_lsb(FD_FIELD_Y, COORD_WIDTH);
    localparam int S_LSB   = fd_lsb(FD_FIELD_S, COORD_WIDTH);
    localparam int H_LSB   = fd_lsb(FD_FIELD_H, COORD_WIDTH);

    localparam logic [CNT_W-1:0]     MAX_CNT = CNT_W'(MAX_DET);
    localparam logic [HIT_WIDTH-1:0] MIN_H   = HIT_WIDTH'(MIN_HITS);

    function automatic logic [HIT_WIDTH-1:0] sat_inc(input logic [HIT_WIDTH-1:0] h);
        return (&h) ? h : h + 1'b1;
    endfunction

    fd_state_t              r_state;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_idx;
    logic                   r_done_pend;
    logic                   r_overflow;
    logic                   r_out_valid;
    logic                   r_readout_done;
    logic [COORD_WIDTH-1:0] r_out_x;
    logic [COORD_WIDTH-1:0] r_out_y;
    logic [COORD_WIDTH-1:0] r_out_s;
    logic [HIT_WIDTH-1:0]   r_out_hits;

    logic [COORD_WIDTH-1:0] r_det_x;
    logic [COORD_WIDTH-1:0] r_det_y;
    logic [COORD_WIDTH-1:0] r_det_s;
    logic [ENTRY_W-1:0]     r_table [MAX_DET];

    logic [IDX_W-1:0]       w_sidx;
    logic [IDX_W-1:0]       w_cidx;
    logic [ENTRY_W-1:0]     w_entry;
    logic [COORD_WIDTH-1:0] w_ent_x;
    logic [COORD_WIDTH-1:0] w_ent_y;
    logic [COORD_WIDTH-1:0] w_ent_s;
    logic [HIT_WIDTH-1:0]   w_ent_h;
    logic                   w_match;
    logic                   w_det_hs;

    assign w_sidx   = r_idx[IDX_W-1:0];
    assign w_cidx   = r_count[IDX_W-1:0];
    assign w_entry  = r_table[w_sidx];
    assign w_ent_x  = w_entry[X_LSB +: COORD_WIDTH];
    assign w_ent_y  = w_entry[Y_LSB +: COORD_WIDTH];
    assign w_ent_s  = w_entry[S_LSB +: COORD_WIDTH];
    assign w_ent_h  = w_entry[H_LSB +: HIT_WIDTH];
    assign w_det_hs = det_valid && det_ready;

    det_match_cmp #(
        .COORD_WIDTH (COORD_WIDTH),
        .MERGE_DIST  (MERGE_DIST)
    ) u_cmp (
        .i_ent_x (w_ent_x),
        .i_ent_y (w_ent_y),
        .i_ent_s (w_ent_s),
        .i_det_x (r_det_x),
        .i_det_y (r_det_y),
        .i_det_s (r_det_s),
        .o_match (w_match)
    );

    // A pending frame_done closes the intake so no new detection slips in first
    assign det_ready    = (r_state == ST_COLLECT) && !r_done_pend;
    assign busy         = (r_state != ST_IDLE);
    assign out_valid    = r_out_valid;
    assign out_x        = r_out_x;
    assign out_y        = r_out_y;
    assign out_scale    = r_out_s;
    assign out_hits     = r_out_hits;
    assign readout_done = r_readout_done;
    assign overflow     = r_overflow;

    // Table and detection latch hold data only; stale contents are masked by r_count
    always_ff @(posedge clk) begin
        if (r_state == ST_COLLECT && w_det_hs) begin
            r_det_x <= det_x;
            r_det_y <= det_y;
            r_det_s <= det_scale;
        end
        if (r_state == ST_INSERT && r_count < MAX_CNT) begin
            r_table[w_cidx] <= {HIT_WIDTH'(1), r_det_s, r_det_y, r_det_x};
        end
        if (r_state == ST_SCAN && w_match) begin
            r_table[w_sidx][H_LSB +: HIT_WIDTH] <= sat_inc(w_ent_h);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_idx          <= '0;
            r_done_pend    <= 1'b0;
            r_overflow     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_readout_done <= 1'b0;
            r_out_x        <= '0;
            r_out_y        <= '0;
            r_out_s        <= '0;
            r_out_hits     <= '0;
        end else begin
            r_readout_done <= 1'b0;
            if (frame_start) begin
                r_state     <= ST_COLLECT;
                r_count     <= '0;
                r_idx       <= '0;
                r_done_pend <= 1'b0;
                r_overflow  <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_COLLECT: begin
                        if (w_det_hs) begin
                            r_idx       <= '0;
                            r_done_pend <= frame_done;
                            r_state     <= (r_count == '0) ? ST_INSERT : ST_SCAN;
                        end else if (frame_done || r_done_pend) begin
                            r_idx       <= '0;
                            r_done_pend <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_state     <= ST_READOUT;
                        end
                    end
                    ST_SCAN: begin
                        r_done_pend <= r_done_pend | frame_done;
                        if (w_match) begin
                            r_state <= ST_COLLECT;
                        end else if (r_idx == r_count - 1'b1) begin
                            r_state <= ST_INSERT;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    ST_INSERT: begin
                        r_done_pend <= r_done_pend | frame_done;
                        if (r_count < MAX_CNT) begin
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                        r_state <= ST_COLLECT;
                    end
                    ST_READOUT: begin
                        // Advance only when nothing is presented or the box was taken
                        if (!r_out_valid || out_ready) begin
                            if (r_idx == r_count) begin
                                r_out_valid    <= 1'b0;
                                r_readout_done <= 1'b1;
                                r_state        <= ST_IDLE;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                                if (w_ent_h >= MIN_H) begin
                                    r_out_valid <= 1'b1;
                                    r_out_x     <= w_ent_x;
                                    r_out_y     <= w_ent_y;
                                    r_out_s     <= w_ent_s;
                                    r_out_hits  <= w_ent_h;
                                end else begin
                                    r_out_valid <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_face_detection_merger.sv
// Self-checking bench for face_detection_merger: directed scenarios plus random
// frames scored against a list-based merge model.
module tb_face_detection_merger;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       det_valid;
    logic       det_ready;
    logic [7:0] det_x;
    logic [7:0] det_y;
    logic [7:0] det_scale;
    logic       frame_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_x;
    logic [7:0] out_y;
    logic [7:0] out_scale;
    logic [3:0] out_hits;
    logic       readout_done;
    logic       overflow;
    logic       busy;

    always #5 clk = ~clk;

    face_detection_merger dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .det_valid    (det_valid),
        .det_ready    (det_ready),
        .det_x        (det_x),
        .det_y        (det_y),
        .det_scale    (det_scale),
        .frame_done   (frame_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_scale    (out_scale),
        .out_hits     (out_hits),
        .readout_done (readout_done),
        .overflow     (overflow),
        .busy         (busy)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] s;
        logic [3:0] h;
    } box_t;

    box_t m_dets[$];
    box_t m_exp[$];
    box_t got[$];
    bit   m_ovf;
    bit   got_done;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic send_det(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s);
        int b;
        b = 0;
        det_x     = x;
        det_y     = y;
        det_scale = s;
        det_valid = 1'b1;
        while (!det_ready && b < 100) begin
            step();
            b++;
        end
        if (!det_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_det_timeout: det_ready=%0b required 1", det_ready);
        end
        step();
        det_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string tag);
        int b;
        b = 0;
        while (!out_valid && b < 100) begin
            step();
            b++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_valid_timeout: out_valid=%0b required 1", tag, out_valid);
        end
    endtask

    // Drains a readout; mode 1 randomizes out_ready each cycle
    task automatic collect(input int mode);
        got.delete();
        got_done = 1'b0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            out_ready = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (readout_done) begin
                got_done = 1'b1;
            end else begin
                if (out_valid && out_ready) got.push_back('{out_x, out_y, out_scale, out_hits});
                step();
            end
        end
        out_ready = 1'b0;
    endtask

    function automatic int adiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // List model: first near entry absorbs the hit, otherwise append if room
    task automatic model_run();
        box_t tab[$];
        int   hit;
        tab.delete();
        m_exp.delete();
        m_ovf = 1'b0;
        foreach (m_dets[k]) begin
            hit = -1;
            foreach (tab[i]) begin
                if (hit < 0 && adiff(tab[i].x, m_dets[k].x) <= 4 && adiff(tab[i].y, m_dets[k].y) <= 4
                    && adiff(tab[i].s, m_dets[k].s) <= 1) hit = i;
            end
            if (hit >= 0) begin
                if (tab[hit].h < 4'd15) tab[hit].h = tab[hit].h + 4'd1;
            end else if (tab.size() < 16) begin
                tab.push_back('{m_dets[k].x, m_dets[k].y, m_dets[k].s, 4'd1});
            end else begin
                m_ovf = 1'b1;
            end
        end
        foreach (tab[i]) if (tab[i].h >= 4'd2) m_exp.push_back(tab[i]);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        n_cmp++; if (det_ready !== 1'b0) begin n_fail++; $display("FAIL reset_det_ready: got %0b want 0", det_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (readout_done !== 1'b0) begin n_fail++; $display("FAIL reset_readout_done: got %0b want 0", readout_done); end
        n_cmp++; if (out_hits !== 4'd0) begin n_fail++; $display("FAIL reset_out_hits: got %0d want 0", out_hits); end
        pulse_start();
        n_cmp++; if (det_ready !== 1'b1) begin n_fail++; $display("FAIL start_det_ready: got %0b want 1", det_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %0b want 1", busy); end
    endtask

    task automatic test_merge();
        box_t want;
        want = '{8'd10, 8'd10, 8'd0, 4'd2};
        pulse_start();
        send_det(8'd10, 8'd10, 8'd0);
        send_det(8'd12, 8'd9, 8'd0);
        send_det(8'd40, 8'd40, 8'd0);
        pulse_done();
        collect(0);
        n_cmp++; if (got.size() != 1) begin n_fail++; $display("FAIL merge_count: got %0d want 1", got.size()); end
        if (got.size() > 0) begin
            n_cmp++; if (got[0] !== want) begin n_fail++; $display("FAIL merge_box: got %h want %h", got[0], want); end
        end
        n_cmp++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL merge_done: got %0b want 1", got_done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL merge_idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_scale_sep();
        box_t want[2];
        want[0] = '{8'd10, 8'd10, 8'd0, 4'd2};
        want[1] = '{8'd10, 8'd10, 8'd2, 4'd2};
        pulse_start();
        send_det(8'd10, 8'd10, 8'd0);
        send_det(8'd10, 8'd10, 8'd2);
        send_det(8'd10, 8'd10, 8'd0);
        send_det(8'd10, 8'd10, 8'd2);
        pulse_done();
        collect(0);
        n_cmp++; if (got.size() != 2) begin n_fail++; $display("FAIL scale_count: got %0d want 2", got.size()); end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== want[i]) begin n_fail++; $display("FAIL scale_box%0d: got %h want %h", i, got[i], want[i]); end
        end
        n_cmp++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL scale_done: got %0b want 1", got_done); end
    endtask

    task automatic test_overflow();
        int b;
        pulse_start();
        for (int i = 0; i < 16; i++) send_det(8'(i * 10), 8'd0, 8'd0);
        b = 0;
        while (!det_ready && b < 100) begin step(); b++; end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %0b want 0", overflow); end
        send_det(8'd160, 8'd0, 8'd0);
        b = 0;
        while (!det_ready && b < 100) begin step(); b++; end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after: got %0b want 1", overflow); end
        pulse_done();
        collect(0);
        n_cmp++; if (got.size() != 0) begin n_fail++; $display("FAIL ovf_boxes: got %0d want 0", got.size()); end
        n_cmp++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %0b want 1", got_done); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_backpressure();
        box_t a;
        box_t b2;
        box_t cur;
        a  = '{8'd10, 8'd10, 8'd0, 4'd2};
        b2 = '{8'd50, 8'd50, 8'd1, 4'd2};
        pulse_start();
        send_det(8'd10, 8'd10, 8'd0);
        send_det(8'd10, 8'd10, 8'd0);
        send_det(8'd50, 8'd50, 8'd1);
        send_det(8'd50, 8'd50, 8'd1);
        out_ready = 1'b0;
        pulse_done();
        wait_out_valid("bp");
        for (int i = 0; i < 5; i++) begin
            cur = '{out_x, out_y, out_scale, out_hits};
            n_cmp++; if (out_valid !== 1'b1 || cur !== a) begin n_fail++; $display("FAIL bp_hold%0d: got v=%0b %h want v=1 %h", i, out_valid, cur, a); end
            step();
        end
        out_ready = 1'b1;
        cur = '{out_x, out_y, out_scale, out_hits};
        n_cmp++; if (out_valid !== 1'b1 || cur !== a) begin n_fail++; $display("FAIL bp_first: got v=%0b %h want v=1 %h", out_valid, cur, a); end
        step();
        cur = '{out_x, out_y, out_scale, out_hits};
        n_cmp++; if (out_valid !== 1'b1 || cur !== b2) begin n_fail++; $display("FAIL bp_second: got v=%0b %h want v=1 %h", out_valid, cur, b2); end
        step();
        n_cmp++; if (readout_done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done: got done=%0b v=%0b want done=1 v=0", readout_done, out_valid); end
        out_ready = 1'b0;
        step();
        n_cmp++; if (readout_done !== 1'b0) begin n_fail++; $display("FAIL bp_done_pulse: got %0b want 0", readout_done); end
    endtask

    task automatic test_abort();
        pulse_start();
        send_det(8'd20, 8'd20, 8'd1);
        send_det(8'd21, 8'd22, 8'd1);
        out_ready = 1'b0;
        pulse_done();
        wait_out_valid("abort");
        pulse_start();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %0b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy: got %0b want 1", busy); end
        n_cmp++; if (det_ready !== 1'b1) begin n_fail++; $display("FAIL abort_det_ready: got %0b want 1", det_ready); end
        pulse_done();
        collect(0);
        n_cmp++; if (got.size() != 0) begin n_fail++; $display("FAIL abort_boxes: got %0d want 0", got.size()); end
        n_cmp++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %0b want 1", got_done); end
    endtask

    task automatic test_mid_reset();
        pulse_start();
        send_det(8'd5, 8'd5, 8'd0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_cmp++; if (busy !== 1'b0 || det_ready !== 1'b0) begin n_fail++; $display("FAIL midrst: got busy=%0b rdy=%0b want 0 0", busy, det_ready); end
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 8; f++) begin
            m_dets.delete();
            n = $urandom_range(5, 30);
            for (int i = 0; i < n; i++)
                m_dets.push_back('{8'($urandom_range(0, 40)), 8'($urandom_range(0, 24)), 8'($urandom_range(0, 3)), 4'd0});
            model_run();
            pulse_start();
            foreach (m_dets[i]) send_det(m_dets[i].x, m_dets[i].y, m_dets[i].s);
            pulse_done();
            collect(1);
            n_cmp++; if (got.size() != m_exp.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", f, got.size(), m_exp.size()); end
            for (int i = 0; i < got.size() && i < m_exp.size(); i++) begin
                n_cmp++; if (got[i] !== m_exp[i]) begin n_fail++; $display("FAIL rand%0d_box%0d: got %h want %h", f, i, got[i], m_exp[i]); end
            end
            n_cmp++; if (got_done !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done: got %0b want 1", f, got_done); end
            n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rand%0d_ovf: got %0b want %0b", f, overflow, m_ovf); end
        end
    endtask

    initial begin
        rst         = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        det_valid   = 1'b0;
        det_x       = '0;
        det_y       = '0;
        det_scale   = '0;
        out_ready   = 1'b0;
        test_reset();
        test_merge();
        test_scale_sep();
        test_overflow();
        test_backpressure();
        test_abort();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/face_detection_merger.md
Name: face_detection_merger

Overview:
Sits directly downstream of the face detector top level and consumes its per-window hit reports (face position, scale, pulse).
- Collects all hits of one frame into a small table.
- Merges near-duplicate hits from neighbouring windows and scales into single entries with a hit count.
- After frame completion, streams the surviving face boxes to the emotion-classifier crop stage over a valid/ready interface.

Parameters:
MAX_DET, 16, table depth (entries per frame)
COORD_WIDTH, 8, width of x, y, scale fields
MERGE_DIST, 4, max |dx| and |dy| in pixels for two hits to merge
MIN_HITS, 2, minimum hit count for an entry to be output
HIT_WIDTH, 4, hit counter width (saturating)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (rst==0 resets on clk rising edge)
frame_start  in  1  pulse: clear table, begin collecting
det_valid  in  1  detection present
det_ready  out  1  merger can accept detection
det_x  in  COORD_WIDTH  window x
det_y  in  COORD_WIDTH  window y
det_scale  in  COORD_WIDTH  window scale index
frame_done  in  1  pulse: detector finished frame
out_valid  out  1  merged box present
out_ready  in  1  consumer accepts box
out_x, out_y, out_scale  out  COORD_WIDTH each  merged box (first-stored coordinates)
out_hits  out  HIT_WIDTH  merged hit count
readout_done  out  1  one-cycle pulse after last qualifying box
overflow  out  1  sticky: a detection was dropped, table full
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; entry count 0; all outputs 0, including det_ready, out_valid, overflow and readout_done.
- States: IDLE, COLLECT, SCAN, INSERT, READOUT.
- IDLE: det_ready=0. On frame_start: count<=0, overflow<=0, go to COLLECT.
- COLLECT: det_ready=1. A handshake (det_valid && det_ready) latches det_x, det_y and det_scale, sets det_ready=0 next cycle, and goes to SCAN with index 0.
- SCAN: compares one table entry per cycle, index 0..count-1.
  - Match rule: |x-det_x|<=MERGE_DIST, |y-det_y|<=MERGE_DIST and |scale-det_scale|<=1.
  - Differences are computed unsigned, at COORD_WIDTH+1 bits.
  - First (lowest-index) match: hits<=hits+1, saturating at 2^HIT_WIDTH-1. Coordinates are unchanged. Return to COLLECT.
  - No match after the last entry, or count==0 on entry to SCAN: go to INSERT.
- INSERT: one cycle.
  - If count<MAX_DET: write entry {det, hits=1} at index count, count++.
  - Else: drop the detection, overflow<=1.
  - Return to COLLECT.
- Detection-to-ready latency: 2 cycles on a first-entry match; count+2 cycles worst case (full scan plus insert).
- frame_done:
  - In COLLECT: go to READOUT, index 0.
  - In SCAN or INSERT: latched in a pending flag and acted on when the state returns to COLLECT. The in-flight detection completes first.
  - In IDLE or READOUT: ignored.
- READOUT:
  - Walks index 0..count-1. Entries with hits<MIN_HITS are skipped at one cycle each.
  - A qualifying entry drives out_valid=1 with its fields. Fields are held stable until out_ready=1.
  - After the handshake, out_valid drops or advances to the next qualifying entry on the following cycle.
  - Index==count: readout_done pulses for 1 cycle, go to IDLE. The table is retained but unreadable until the next frame_start.
- frame_start has priority in every state:
  - Aborts SCAN, INSERT or READOUT.
  - Clears count and overflow; out_valid=0 next cycle; go to COLLECT.
  - A detection handshaking in the same cycle is discarded.
- frame_start and frame_done in the same cycle: frame_start wins.
- rst==0 mid-operation: full reset regardless of state.
- Count width is $clog2(MAX_DET+1).
- Table is register-based, MAX_DET x (3*COORD_WIDTH+HIT_WIDTH).

Decomposition:
- Shared package face_det_pkg:
  - COORD_WIDTH and HIT_WIDTH defaults.
  - Detection-entry field layout (x, y, scale, hits bit offsets).
  - State encoding localparams for the merger.
- One sub-module, det_match_cmp: combinational match of one stored entry against the latched detection (abs diffs, MERGE_DIST compare, scale ±1). Instantiated once, driven by the SCAN index mux.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → det_ready=0, out_valid=0, overflow=0, busy=0; after frame_start, det_ready=1 on the next cycle.
- Merge: frame_start, then dets (10,10,0), (12,9,0), (40,40,0), then frame_done → exactly one box out (10,10,0, hits=2), then a readout_done pulse. (40,40,0) is suppressed (hits=1 < MIN_HITS).
- Scale separation: dets (10,10,0), (10,10,2), (10,10,0), (10,10,2) → two boxes in order: (10,10,0, hits=2), (10,10,2, hits=2).
- Overflow: 17 dets at x=0,10,...,160, y=0, scale=0 → overflow=1 after the 17th; 17th is dropped; count stays 16; readout emits 0 boxes and readout_done pulses.
- Backpressure: two qualifying entries with out_ready=0 for 5 cycles → out_valid stays 1 with stable fields; with out_ready=1 both boxes transfer on consecutive cycles, then readout_done.
- Abort: frame_start asserted during READOUT while out_valid=1 → out_valid=0 next cycle, busy=1, det_ready=1, prior entries gone (immediate frame_done yields only readout_done).
